// File: rtl/nms_stream.sv
// Streaming non-maximum suppression: two line buffers feed a 3x3 window whose centre
// magnitude survives only if it is a local maximum along its own quantised direction.
module nms_stream #(
    parameter int MAG_W = 11,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic signed [MAG_W-1:0] in_mag,
    input  logic [1:0]              in_dir,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic signed [MAG_W-1:0] out_mag
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [XW-1:0]   x_reg, ox_reg;
    logic [YW-1:0]   y_reg, oy_reg;
    logic [FW-1:0]   fcnt_reg;

    // Magnitudes only travel through both buffers; direction is needed for the centre alone.
    logic signed [MAG_W-1:0] lb1 [IMG_W];
    logic signed [MAG_W-1:0] lb2 [IMG_W];
    logic [1:0]              dlb1 [IMG_W];
    logic signed [MAG_W-1:0] win_reg [3][2];
    logic [1:0]              cdir_reg;

    logic signed [MAG_W-1:0] pix, c, n1, n2;
    logic signed [MAG_W-1:0] col_new [3];
    logic [1:0]              pix_dir;
    logic accept, start, take, adv, emit, last_in, border, keep;

    assign in_ready = (state_reg != FLUSH);
    assign accept   = in_valid & in_ready;
    assign start    = accept & in_sof;
    assign take     = accept & ((state_reg != IDLE) | in_sof);
    assign adv      = take | (state_reg == FLUSH);
    // An abort pixel belongs to the new frame, so it never produces an old-frame output.
    assign emit     = ((state_reg == RUN) & take & ~in_sof) | (state_reg == FLUSH);
    assign last_in  = (x_reg == XW'(IMG_W - 1)) && (y_reg == YW'(IMG_H - 1));
    assign pix      = (state_reg == FLUSH || in_mag[MAG_W-1]) ? '0 : in_mag;
    assign pix_dir  = (state_reg == FLUSH) ? 2'b00 : in_dir;

    assign col_new[0] = lb2[x_reg];
    assign col_new[1] = lb1[x_reg];
    assign col_new[2] = pix;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (start) state_next = FILL;
                     else if (take && x_reg == '0 && y_reg == YW'(1)) state_next = RUN;
            RUN:     if (start) state_next = FILL;
                     else if (take && last_in) state_next = FLUSH;
            FLUSH:   if (fcnt_reg == FW'(IMG_W)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            ox_reg    <= '0;
            oy_reg    <= '0;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= (state_reg == FLUSH) ? fcnt_reg + FW'(1) : '0;
            if (start) begin
                x_reg  <= XW'(1);
                y_reg  <= '0;
                ox_reg <= '0;
                oy_reg <= '0;
            end else begin
                if (adv) begin
                    if (x_reg == XW'(IMG_W - 1)) begin
                        x_reg <= '0;
                        y_reg <= y_reg + YW'(1);
                    end else begin
                        x_reg <= x_reg + XW'(1);
                    end
                end
                if (emit) begin
                    if (ox_reg == XW'(IMG_W - 1)) begin
                        ox_reg <= '0;
                        oy_reg <= (oy_reg == YW'(IMG_H - 1)) ? '0 : oy_reg + YW'(1);
                    end else begin
                        ox_reg <= ox_reg + XW'(1);
                    end
                end
            end
        end
    end

    // Line buffers and window hold data only; the border rule masks anything stale.
    always_ff @(posedge clk) begin
        if (adv) begin
            lb1[x_reg]  <= pix;
            lb2[x_reg]  <= lb1[x_reg];
            dlb1[x_reg] <= pix_dir;
            cdir_reg    <= dlb1[x_reg];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            always_ff @(posedge clk) begin
                if (adv) begin
                    win_reg[gi][0] <= win_reg[gi][1];
                    win_reg[gi][1] <= col_new[gi];
                end
            end
        end
    endgenerate

    // Column 0 is west of the centre, column 1 the centre, col_new the east column.
    assign c = win_reg[1][1];

    always_comb begin
        n1 = win_reg[1][0];
        n2 = col_new[1];
        case (cdir_reg)
            2'b00: begin n1 = win_reg[1][0]; n2 = col_new[1];    end
            2'b01: begin n1 = win_reg[0][1]; n2 = win_reg[2][1]; end
            2'b10: begin n1 = col_new[0];    n2 = win_reg[2][0]; end
            2'b11: begin n1 = win_reg[0][0]; n2 = col_new[2];    end
            default: ;
        endcase
    end

    assign keep   = (c >= n1) && (c >= n2);
    assign border = (ox_reg == '0) || (ox_reg == XW'(IMG_W - 1)) ||
                    (oy_reg == '0) || (oy_reg == YW'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_mag   <= '0;
        end else begin
            out_valid <= emit;
            out_sof   <= emit && ox_reg == '0 && oy_reg == '0;
            out_eof   <= emit && ox_reg == XW'(IMG_W - 1) && oy_reg == YW'(IMG_H - 1);
            if (emit) out_mag <= (border || !keep) ? '0 : c;
        end
    end
endmodule

// File: tb/tb_nms_stream.sv
// Directed bench for nms_stream on a 4x3 frame; expected outputs are hand-computed tables.
module tb_nms_stream;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int MW = 11;
    localparam int N  = W * H;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_sof = 1'b0;
    logic signed [MW-1:0] in_mag = '0;
    logic [1:0] in_dir = 2'b00;
    logic in_ready, out_valid, out_sof, out_eof;
    logic signed [MW-1:0] out_mag;

    always #5 clk = ~clk;

    nms_stream #(.MAG_W(MW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_mag(in_mag), .in_dir(in_dir),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_mag(out_mag)
    );

    int errors = 0, checks = 0;
    logic signed [MW-1:0] q_mag [256];
    logic [1:0]           q_fl  [256];
    int n_out = 0, eof_total = 0, neg_seen = 0;

    always @(negedge clk) begin
        if (out_valid && n_out < 256) begin
            q_mag[n_out] <= out_mag;
            q_fl[n_out]  <= {out_sof, out_eof};
            n_out        <= n_out + 1;
            eof_total    <= eof_total + (out_eof ? 1 : 0);
            neg_seen     <= neg_seen + ((out_mag < 0) ? 1 : 0);
            $display("out #%0d mag=%0d sof=%0b eof=%0b", n_out, out_mag, out_sof, out_eof);
        end
    end

    logic signed [MW-1:0] f_mag [N];
    logic [1:0]           f_dir [N];
    logic signed [MW-1:0] e_mag [N];

    task automatic set_all(input logic signed [MW-1:0] m, input logic [1:0] d);
        for (int i = 0; i < N; i++) begin
            f_mag[i] = m;
            f_dir[i] = d;
            e_mag[i] = '0;
        end
    endtask

    task automatic send_px(input logic signed [MW-1:0] m, input logic [1:0] d, input logic s);
        int g;
        @(negedge clk);
        in_valid = 1'b1; in_sof = s; in_mag = m; in_dir = d;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            checks++; errors++;
            $error("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_px(f_mag[i], f_dir[i], (i == 0));
    endtask

    task automatic expect_frame(input int base, input string tag, input bit chk_cnt);
        int g;
        g = 0;
        while (n_out < base + N && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (8) @(negedge clk);
        if (chk_cnt) begin
            checks++;
            assert (n_out - base === N) else begin
                errors++;
                $error("FAIL %s count got %0d required %0d", tag, n_out - base, N);
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            assert (q_mag[base+i] === e_mag[i]) else begin
                errors++;
                $error("FAIL %s mag[%0d] got %0d required %0d", tag, i, q_mag[base+i], e_mag[i]);
            end
            checks++;
            assert (q_fl[base+i] === {(i == 0), (i == N - 1)}) else begin
                errors++;
                $error("FAIL %s sof_eof[%0d] got %b required %b", tag, i, q_fl[base+i],
                       {(i == 0), (i == N - 1)});
            end
        end
    endtask

    int base, eof_base, cnt;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checks++;
        assert ({out_valid, out_sof, out_eof, in_ready} === 4'b0001 && out_mag === '0) else begin
            errors++;
            $error("FAIL reset_state got v/s/e/r=%b%b%b%b mag=%0d required 0001 mag=0",
                   out_valid, out_sof, out_eof, in_ready, out_mag);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Constant frame: only interior pixels survive via ties
        set_all(11'sd5, 2'b00); e_mag[5] = 11'sd5; e_mag[6] = 11'sd5;
        base = n_out; send_range(0, N - 1); expect_frame(base, "const", 1'b1);

        // Direction select: centre 8, west 9
        set_all(11'sd0, 2'b00); f_mag[5] = 11'sd8; f_mag[4] = 11'sd9;
        base = n_out; send_range(0, N - 1); expect_frame(base, "dir00", 1'b1);
        set_all(11'sd0, 2'b01); f_mag[5] = 11'sd8; f_mag[4] = 11'sd9; e_mag[5] = 11'sd8;
        base = n_out; send_range(0, N - 1); expect_frame(base, "dir01", 1'b1);
        // NE (2,0) and SW (0,2) = 9
        set_all(11'sd0, 2'b10); f_mag[5] = 11'sd8; f_mag[2] = 11'sd9; f_mag[8] = 11'sd9;
        base = n_out; send_range(0, N - 1); expect_frame(base, "dir10", 1'b1);
        set_all(11'sd0, 2'b11); f_mag[5] = 11'sd8; f_mag[2] = 11'sd9; f_mag[8] = 11'sd9;
        e_mag[5] = 11'sd8;
        base = n_out; send_range(0, N - 1); expect_frame(base, "dir11", 1'b1);

        // Negative clamp
        set_all(11'sd0, 2'b00); f_mag[6] = -11'sd3;
        base = n_out; send_range(0, N - 1); expect_frame(base, "neg_one", 1'b1);
        set_all(-11'sd3, 2'b00);
        base = n_out; send_range(0, N - 1); expect_frame(base, "neg_all", 1'b1);

        // Back-to-back frames: flush window length
        set_all(11'sd5, 2'b00); e_mag[5] = 11'sd5; e_mag[6] = 11'sd5;
        base = n_out; send_range(0, N - 1);
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; in_mag = 11'sd0; in_dir = 2'b01;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        assert (cnt === W + 1) else begin
            errors++;
            $error("FAIL flush_len got %0d required %0d", cnt, W + 1);
        end
        @(posedge clk); #1; in_valid = 1'b0; in_sof = 1'b0;
        expect_frame(base, "b2b_a", 1'b0);
        set_all(11'sd0, 2'b01); f_mag[5] = 11'sd8; f_mag[4] = 11'sd9; e_mag[5] = 11'sd8;
        send_range(1, N - 1); expect_frame(base + N, "b2b_b", 1'b1);

        // Abort at raster index 6
        eof_base = eof_total;
        set_all(11'sd7, 2'b00);
        send_range(0, 5);
        set_all(11'sd5, 2'b00); e_mag[5] = 11'sd5; e_mag[6] = 11'sd5;
        send_px(f_mag[0], f_dir[0], 1'b1);
        base = n_out;
        send_range(1, N - 1); expect_frame(base, "abort", 1'b1);
        checks++;
        assert (eof_total - eof_base === 1) else begin
            errors++;
            $error("FAIL abort_eof got %0d required 1", eof_total - eof_base);
        end

        // Asynchronous reset during flush, then clean restart
        set_all(11'sd5, 2'b00);
        send_range(0, N - 1);
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b1 && in_ready === 1'b0) else begin
            errors++;
            $error("FAIL pre_rst got v=%b r=%b required v=1 r=0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
            errors++;
            $error("FAIL async_rst got v=%b r=%b required v=0 r=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_all(11'sd5, 2'b00); e_mag[5] = 11'sd5; e_mag[6] = 11'sd5;
        base = n_out; send_range(0, N - 1); expect_frame(base, "restart", 1'b1);

        checks++;
        assert (neg_seen === 0) else begin
            errors++;
            $error("FAIL negative_out got %0d required 0", neg_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
